// File: rtl/trap_capture_arbiter_pkg.sv
// trap_capture_arbiter_pkg: shared FSM encoding and default timing values for the trap capture arbiter
package trap_capture_arbiter_pkg;
   typedef enum logic [1:0] {IDLE, HOLD, RELEASE, COOLDOWN} state_t;
   localparam int DEFAULT_FRAMES_PER_SECOND = 60;
   localparam int DEFAULT_HOLD_SECONDS      = 5;
   localparam int DEFAULT_COOLDOWN_SECONDS  = 2;
endpackage

// File: rtl/rr_priority_select.sv
// rr_priority_select: picks the first requester at or above ptr, wrapping modulo N
module rr_priority_select #(
   parameter int N = 4
) (
   input  logic [N-1:0] req,
   input  logic [2:0]   ptr,
   output logic         valid,
   output logic [2:0]   index
);
   logic [N-1:0] rot;
   // rotate so bit 0 is the requester at ptr, then scan downward so the lowest offset wins
   always_comb begin
      rot = N'({req, req} >> ptr);
      valid = 1'b0;
      index = 3'd0;
      for (int i = N - 1; i >= 0; i--) begin
         if (rot[i]) begin
            valid = 1'b1;
            index = 3'((int'(ptr) + i) % N);
         end
      end
   end
endmodule

// File: rtl/trap_capture_arbiter.sv
// trap_capture_arbiter: grants the ball to one trap, counts down the hold, then locks out new captures
module trap_capture_arbiter
   import trap_capture_arbiter_pkg::*;
#(
   parameter int NUM_TRAPS         = 4,
   parameter int FRAMES_PER_SECOND = DEFAULT_FRAMES_PER_SECOND,
   parameter int HOLD_SECONDS      = DEFAULT_HOLD_SECONDS,
   parameter int COOLDOWN_SECONDS  = DEFAULT_COOLDOWN_SECONDS
) (
   input  logic                 clk,
   input  logic                 resetN,
   input  logic                 startOfFrame,
   input  logic                 reset_level_pulse,
   input  logic                 pause,
   input  logic [NUM_TRAPS-1:0] collisionBallTrap,
   output logic                 controlledByTrap,
   output logic [2:0]           grantIndex,
   output logic [3:0]           countDownNumber,
   output logic                 releasePulse,
   output logic [NUM_TRAPS-1:0] trapEnable
);
   localparam int COOL_FRAMES = COOLDOWN_SECONDS * FRAMES_PER_SECOND;
   localparam int CW = $clog2(COOL_FRAMES + 1);
   localparam int HW = $clog2(FRAMES_PER_SECOND + 1);
   localparam int FW = (CW > 6) ? ((CW > HW) ? CW : HW) : ((HW > 6) ? HW : 6);
   localparam logic [FW-1:0] HOLD_LAST = FW'(FRAMES_PER_SECOND - 1);
   localparam logic [FW-1:0] COOL_LAST = FW'(COOL_FRAMES - 1);

   state_t        state;
   logic [2:0]    rr_ptr;
   logic [FW-1:0] frame_cnt;
   logic          hit_valid;
   logic [2:0]    hit_index;
   logic          frame_tick;

   assign frame_tick = startOfFrame & ~pause;

   rr_priority_select #(.N(NUM_TRAPS)) u_select (
      .req   (trapEnable & collisionBallTrap),
      .ptr   (rr_ptr),
      .valid (hit_valid),
      .index (hit_index)
   );

   // capture / hold / release / cooldown sequencing; a level restart overrides everything like a reset
   always_ff @(posedge clk) begin
      if (!resetN || reset_level_pulse) begin
         state            <= IDLE;
         rr_ptr           <= 3'd0;
         frame_cnt        <= '0;
         controlledByTrap <= 1'b0;
         grantIndex       <= 3'd0;
         countDownNumber  <= 4'd0;
         releasePulse     <= 1'b0;
         trapEnable       <= '1;
      end else begin
         case (state)
            IDLE: if (hit_valid) begin
               state            <= HOLD;
               controlledByTrap <= 1'b1;
               grantIndex       <= hit_index;
               rr_ptr           <= (hit_index == 3'(NUM_TRAPS - 1)) ? 3'd0 : hit_index + 3'd1;
               countDownNumber  <= 4'(HOLD_SECONDS);
               frame_cnt        <= '0;
               trapEnable       <= '0;
            end
            HOLD: if (frame_tick) begin
               if (frame_cnt == HOLD_LAST) begin
                  frame_cnt       <= '0;
                  countDownNumber <= countDownNumber - 4'd1;
                  if (countDownNumber == 4'd1) begin
                     state            <= RELEASE;
                     releasePulse     <= 1'b1;
                     controlledByTrap <= 1'b0;
                  end
               end else begin
                  frame_cnt <= frame_cnt + FW'(1);
               end
            end
            RELEASE: begin
               releasePulse <= 1'b0;
               frame_cnt    <= '0;
               state        <= (COOLDOWN_SECONDS == 0) ? IDLE : COOLDOWN;
               trapEnable   <= {NUM_TRAPS{COOLDOWN_SECONDS == 0}};
            end
            COOLDOWN: if (frame_tick) begin
               if (frame_cnt == COOL_LAST) begin
                  state      <= IDLE;
                  frame_cnt  <= '0;
                  trapEnable <= '1;
               end else begin
                  frame_cnt <= frame_cnt + FW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: doc/trap_capture_arbiter.md
TRAP_CAPTURE_ARBITER -- requirements
Module: trap_capture_arbiter

Interface
REQ-001 Parameter NUM_TRAPS, default 4: number of trap requesters, range 2..8.
REQ-002 Parameter FRAMES_PER_SECOND, default 60: startOfFrame pulses per countdown step.
REQ-003 Parameter HOLD_SECONDS, default 5: countdown start value, range 1..15.
REQ-004 Parameter COOLDOWN_SECONDS, default 2: post-release lockout length, range 0..15.
REQ-005 clk, input, 1: single system clock.
REQ-006 resetN, input, 1: synchronous, active-low reset.
REQ-007 startOfFrame, input, 1: one-clk pulse per video frame.
REQ-008 reset_level_pulse, input, 1: one-clk level-restart request.
REQ-009 pause, input, 1: while high, freezes frame counting.
REQ-010 collisionBallTrap, input, NUM_TRAPS: per-trap ball-collision flags, sampled every clk.
REQ-011 controlledByTrap, output, 1: ball is held by a trap.
REQ-012 grantIndex, output, 3: index of the trap currently holding the ball.
REQ-013 countDownNumber, output, 4: seconds remaining until release.
REQ-014 releasePulse, output, 1: one-clk pulse when the ball is released.
REQ-015 trapEnable, output, NUM_TRAPS: per-trap capture-eligible flags.

Function
REQ-016 The block SHALL implement the FSM states IDLE, HOLD, RELEASE and COOLDOWN.
REQ-017 In IDLE, when any trapEnable&collisionBallTrap bit is set, the block SHALL enter HOLD on the next clk, with controlledByTrap=1 and grantIndex equal to the winner.
REQ-018 The winner SHALL be chosen round-robin: the first requesting index at or above rrPtr, wrapping modulo NUM_TRAPS. After each grant, rrPtr SHALL become winner+1, with wrap.
REQ-019 On entry to HOLD, countDownNumber SHALL load HOLD_SECONDS and the frame counter SHALL clear.
REQ-020 In HOLD, each startOfFrame with pause low SHALL increment the frame counter. At FRAMES_PER_SECOND counts, the counter SHALL clear and countDownNumber SHALL decrement.
REQ-021 When countDownNumber decrements from 1 to 0, the block SHALL enter RELEASE. RELEASE SHALL last exactly one clk, with releasePulse=1 and controlledByTrap=0.
REQ-022 From RELEASE, the block SHALL enter COOLDOWN, or enter IDLE directly if COOLDOWN_SECONDS=0.
REQ-023 COOLDOWN SHALL count COOLDOWN_SECONDS*FRAMES_PER_SECOND unpaused startOfFrame pulses, then enter IDLE.
REQ-024 trapEnable SHALL be all-ones in IDLE and all-zeros in HOLD, RELEASE and COOLDOWN. Collisions outside IDLE SHALL be ignored and SHALL NOT be queued.
REQ-025 countDownNumber SHALL be 0 outside HOLD. grantIndex SHALL keep its last value outside HOLD.
REQ-026 If startOfFrame and pause are high in the same clk, the frame SHALL NOT be counted.
REQ-027 reset_level_pulse SHALL take priority over every other event in any state. On the next clk it SHALL force IDLE, rrPtr=0, both counters=0 and all outputs to their reset values.
REQ-028 A collision coincident with reset_level_pulse SHALL be discarded.
REQ-029 The frame counter width SHALL be clog2(COOLDOWN_SECONDS*FRAMES_PER_SECOND+1) or 6 bits, whichever is larger. Arithmetic SHALL never wrap.

Reset
REQ-030 With resetN low at a clk edge, the block SHALL set state=IDLE, rrPtr=0, counters=0, controlledByTrap=0, grantIndex=0, countDownNumber=0, releasePulse=0 and trapEnable=all-ones.
REQ-031 Reset asserted mid-HOLD SHALL release control with no releasePulse.

Structure
REQ-032 The FSM state enum and the default FRAMES_PER_SECOND, HOLD_SECONDS and COOLDOWN_SECONDS values SHALL reside in the shared defines package.
REQ-033 The round-robin winner selection SHALL be one combinational sub-module, rr_priority_select, with inputs req and ptr and outputs valid and index.

Verification (test parameters NUM_TRAPS=4, FRAMES_PER_SECOND=2, HOLD_SECONDS=3, COOLDOWN_SECONDS=1)
REQ-034 Capture and countdown: a single collision on trap 2 in IDLE SHALL give, on the next clk, controlledByTrap=1, grantIndex=2 and countDownNumber=3. After 2, 4 and 6 unpaused frames, countDownNumber SHALL read 2, 1 and 0 respectively. releasePulse SHALL pulse once. After 2 further frames, the block SHALL be in IDLE with trapEnable=4'b1111.
REQ-035 Round-robin: with rrPtr=3 (after a grant to trap 2), simultaneous collisions on traps 0 and 1 SHALL grant trap 0. The next simultaneous 0/1 collision SHALL grant trap 1.
REQ-036 Pause: 10 startOfFrame pulses with pause=1 during HOLD SHALL leave countDownNumber unchanged at 3. A startOfFrame coincident with pause SHALL NOT be counted.
REQ-037 Lockout: a collision on trap 1 during HOLD or COOLDOWN SHALL cause no grant change and SHALL NOT produce a later grant once IDLE is reached.
REQ-038 Level reset: reset_level_pulse at countDownNumber=2, coincident with a trap 3 collision, SHALL give IDLE on the next clk, with controlledByTrap=0, countDownNumber=0, no releasePulse and rrPtr=0.
REQ-039 Hardware reset: resetN low for 1 clk mid-COOLDOWN SHALL give all REQ-030 values on the next clk.
